// File: rtl/fp16_class_counter.sv
// rtl/fp16_class_counter.sv - per-class occurrence counters for fp16 classifier flags
module fp16_class_counter #(
    parameter int CNT_W = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_class,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             onehot_err,
    output logic             busy
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [3:0]       sidx;
    logic [CNT_W-1:0] cnt [10];
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] rd_mux;
    logic             accept;
    logic             is_onehot;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (SAT && (&v)) return v;
        return v + ONE;
    endfunction

    assign accept    = in_valid && in_ready;
    assign is_onehot = (in_class != 10'd0) && ((in_class & (in_class - 10'd1)) == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clear) state_nxt = S_CLEAR;
            S_CLEAR: if (sidx == 4'd9) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state == S_CLEAR);
    end

    // A clear on the same edge as an accepted beat takes priority; the beat is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sidx       <= 4'd0;
            total      <= '0;
            onehot_err <= 1'b0;
            for (int i = 0; i < 10; i++) cnt[i] <= '0;
        end else if (state == S_CLEAR) begin
            for (int i = 0; i < 10; i++)
                if (sidx == 4'(i)) cnt[i] <= '0;
            sidx <= sidx + 4'd1;
        end else if (clear) begin
            sidx       <= 4'd0;
            total      <= '0;
            onehot_err <= 1'b0;
        end else if (accept) begin
            total <= bump(total);
            if (is_onehot) begin
                for (int i = 0; i < 10; i++)
                    if (in_class[i]) cnt[i] <= bump(cnt[i]);
            end else begin
                onehot_err <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_idx == 4'd10) rd_mux = total;
        for (int i = 0; i < 10; i++)
            if (rd_idx == 4'(i)) rd_mux = cnt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_fp16_class_counter.sv
// tb/tb_fp16_class_counter.sv - scoreboard bench for fp16_class_counter across width/saturation variants
module tb_fp16_class_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_class = 10'd0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_idx = 4'd0;
    wire  [2:0]  rv, ir, bz, oe;
    wire  [15:0] rd0;
    wire  [3:0]  rd1, rd2;

    always #5 clk = ~clk;

    fp16_class_counter #(.CNT_W(16), .SAT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_class(in_class),
        .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rv[0]), .rd_data(rd0),
        .onehot_err(oe[0]), .busy(bz[0]));
    fp16_class_counter #(.CNT_W(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_class(in_class),
        .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rv[1]), .rd_data(rd1),
        .onehot_err(oe[1]), .busy(bz[1]));
    fp16_class_counter #(.CNT_W(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_class(in_class),
        .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rv[2]), .rd_data(rd2),
        .onehot_err(oe[2]), .busy(bz[2]));

    int n_vec = 0;
    int n_err = 0;
    int q0[$], q1[$], q2[$];

    // Model: true event counts since the last clear; width/saturation applied only when read.
    int m_cnt[11];
    bit m_err;
    int sweep = -1;
    bit last_re = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s[%0d] got %0d exp %0d", nm, i, act, exp);
        end
    endtask

    function automatic int map_cnt(input int n, input int i);
        int w  = (i == 0) ? 16 : 4;
        int mx = (1 << w) - 1;
        if (i != 2) return (n > mx) ? mx : n;
        return n % (mx + 1);
    endfunction

    function automatic logic [31:0] rdat(input int i);
        case (i)
            0:       return {16'd0, rd0};
            1:       return {28'd0, rd1};
            default: return {28'd0, rd2};
        endcase
    endfunction

    task automatic push(input int i, input int v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_chk(input int i);
        int sz, v;
        sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk("rd_unexpected", i, 1, 0);
        end else begin
            case (i)
                0:       v = q0.pop_front();
                1:       v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
            chk("rd_data", i, rdat(i), v);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_err = 1'b0;
        sweep = -1;
    endtask

    task automatic step(input bit v, input logic [9:0] cls, input bit clr,
                        input bit re, input logic [3:0] idx);
        @(negedge clk);
        in_valid = v; in_class = cls; clear = clr; rd_en = re; rd_idx = idx;
        last_re = re;
        if (re)
            for (int i = 0; i < 3; i++)
                push(i, (idx <= 4'd10) ? map_cnt(m_cnt[idx], i) : 0);
        if (sweep < 0) begin
            if (clr) begin
                m_cnt[10] = 0; m_err = 1'b0; sweep = 0;
            end else if (v) begin
                m_cnt[10]++;
                if ($countones(cls) == 1) begin
                    for (int k = 0; k < 10; k++) if (cls[k]) m_cnt[k]++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            m_cnt[sweep] = 0;
            sweep++;
            if (sweep == 10) sweep = -1;
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 10'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic read_all();
        for (int k = 0; k <= 10; k++) step(1'b0, 10'd0, 1'b0, 1'b1, 4'(k));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; clear = 1'b0; rd_en = 1'b0; last_re = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle compare status against the model; pop the scoreboard on rd_valid.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                chk("in_ready", i, 32'(ir[i]), (sweep < 0) ? 1 : 0);
                chk("busy", i, 32'(bz[i]), (sweep >= 0) ? 1 : 0);
                chk("onehot_err", i, 32'(oe[i]), int'(m_err));
                chk("rd_valid", i, 32'(rv[i]), int'(last_re && rst_n));
                if (rv[i] === 1'b1) pop_chk(i);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        #1;
        for (int i = 0; i < 3; i++) chk("reset_rd_data", i, rdat(i), 0);

        for (int k = 0; k < 10; k++) step(1'b1, 10'(1 << k), 1'b0, 1'b0, 4'd0);
        read_all();

        step(1'b0, 10'd0, 1'b1, 1'b0, 4'd0);
        idle(10);
        step(1'b1, 10'b0000000011, 1'b0, 1'b0, 4'd0);
        step(1'b1, 10'b0000000000, 1'b0, 1'b0, 4'd0);
        read_all();
        step(1'b0, 10'd0, 1'b1, 1'b0, 4'd0);
        idle(10);

        for (int c = 0; c < 20; c++) step(1'b1, 10'(1 << 8), 1'b0, 1'b0, 4'd0);
        step(1'b0, 10'd0, 1'b0, 1'b1, 4'd8);
        step(1'b0, 10'd0, 1'b0, 1'b1, 4'd10);

        // Beat held valid across a whole sweep: stalls, then counts exactly once.
        step(1'b0, 10'd0, 1'b1, 1'b0, 4'd0);
        begin
            int guard = 0;
            while (sweep >= 0 && guard < 20) begin
                step(1'b1, 10'(1 << 6), 1'b0, 1'b0, 4'd0);
                guard++;
            end
            step(1'b1, 10'(1 << 6), 1'b0, 1'b0, 4'd0);
        end
        read_all();

        for (int c = 0; c < 2; c++) step(1'b1, 10'(1 << 6), 1'b0, 1'b0, 4'd0);
        step(1'b1, 10'(1 << 6), 1'b0, 1'b1, 4'd6);
        step(1'b0, 10'd0, 1'b0, 1'b1, 4'd6);

        step(1'b1, 10'(1 << 2), 1'b1, 1'b1, 4'd2);
        step(1'b0, 10'd0, 1'b0, 1'b1, 4'd10);
        idle(10);
        read_all();

        for (int c = 0; c < 500; c++) begin
            logic [9:0] cls;
            cls = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'(1 << $urandom_range(0, 9));
            step($urandom_range(0, 3) != 0, cls, $urandom_range(0, 39) == 0,
                 1'($urandom), 4'($urandom));
        end
        idle(10);
        read_all();

        step(1'b0, 10'd0, 1'b1, 1'b0, 4'd0);
        idle(4);
        do_reset();
        read_all();

        idle(3);
        chk("scoreboard_drain", 0, 32'(q0.size() + q1.size() + q2.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/fp16_class_counter.md
Name: fp16_class_counter

Overview:
- Downstream consumer of the fp16 classifier's ten class flags.
- Accepts one classified sample per cycle over a valid/ready handshake and keeps a per-class occurrence counter (10 classes).
- Also keeps a total-beat counter and a sticky one-hot error flag.
- Counters are read back through an indexed, 1-cycle-latency read port; a clear command sweeps them to zero through a small FSM. Used for stimulus-coverage statistics and on-chip FP health monitoring.

Parameters:
- CNT_W, 16, width of each class counter and of the total counter.
- SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  class vector valid.
- in_ready  output  1  block can accept a beat.
- in_class  input  10  class flags. Bit order: [0] is_snan, [1] is_qnan, [2] is_neg_inf, [3] is_neg_normal, [4] is_neg_denormal, [5] is_neg_zero, [6] is_pos_zero, [7] is_pos_denormal, [8] is_pos_normal, [9] is_pos_inf.
- clear  input  1  single-cycle pulse requesting a counter sweep.
- rd_en  input  1  read request.
- rd_idx  input  4  counter index: 0..9 = class counters, 10 = total, 11..15 = reserved.
- rd_valid  output  1  rd_data valid.
- rd_data  output  CNT_W  read result.
- onehot_err  output  1  sticky; set when an accepted beat is not exactly one-hot.
- busy  output  1  clear sweep in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all counters 0, total 0, onehot_err 0, rd_valid 0, rd_data 0, busy 0, FSM = IDLE, in_ready 1 once rst_n deasserts.
- FSM states:
  - IDLE: in_ready=1, busy=0. clear=1 moves to CLEAR with sweep index sidx=0, clears onehot_err and total in that same edge, and in_ready drops in the next cycle.
  - CLEAR: in_ready=0, busy=1. Each cycle writes counter[sidx]=0 and increments sidx. After sidx=9 is written, returns to IDLE, so CLEAR lasts exactly 10 cycles.
  - clear asserted while in CLEAR is ignored, with no restart.
- Accept: beat accepted when in_valid && in_ready. in_ready depends only on state, never on in_valid.
- Counting on an accepted beat:
  - If in_class is exactly one-hot, counter[k] += 1 for the set bit k.
  - Otherwise no class counter changes and onehot_err is set (including in_class = 0).
  - total += 1 on every accepted beat, error beats included.
- Same-edge events in IDLE:
  - clear and an accepted beat on the same edge: the beat is accepted but discarded. No counter, total or onehot_err update; clear wins.
- Arithmetic: with SAT=1, a counter at 2^CNT_W-1 stays there. With SAT=0 it wraps to 0. total follows the same rule.
- Read port: rd_en sampled every cycle in any state.
  - Next cycle: rd_valid=1 and rd_data = value of the addressed counter before the same-edge update. A read and an increment of the same counter in one cycle return the old value.
  - rd_idx 11..15 returns 0 with rd_valid=1.
  - rd_valid=0 in any cycle following rd_en=0; rd_data then holds its last value.
  - Reads during CLEAR return the counter's current (partly swept) value.
- Reset mid-sweep: immediate return to IDLE, all state zeroed.
- No combinational path from in_valid, in_class, clear or rd_* to any output.

Test Plan:
- Reset then one beat each of classes 0..9 (in_class = 1<<k), then read idx 0..10 -> each class counter = 1, total = 10, onehot_err = 0, rd_valid one cycle after each rd_en.
- Send in_class = 10'b0000000011 and 10'b0 on accepted beats -> onehot_err = 1 sticky, class counters unchanged, total = 2; a later clear returns onehot_err to 0.
- CNT_W=4, SAT=1, 20 beats of pos_normal -> counter[8] = 15, total = 15. With SAT=0 -> counter[8] = 4, total = 4.
- clear pulse, then in_valid held high -> in_ready=0 and busy=1 for exactly 10 cycles, beats stall without loss. After the sweep all reads return 0 and the stalled beat is counted once.
- Same-cycle read of idx 6 while a pos_zero beat is accepted, with counter[6]=3 -> rd_data = 3; a subsequent read returns 4.
- rst_n asserted on cycle 5 of a sweep -> busy=0 and in_ready=1 after release, all counters and total 0, rd_valid=0.
